// File: rtl/dmem_responder.sv
// dmem_responder: word-wide data-memory responder for the nano_rv32i core.
// It accepts one load or store per request and stalls the core for
// WAIT_CYCLES wait states. Misaligned, out-of-range and conflicting
// requests are rejected with err_o.
//
// Ports:
//   clk_i        clock, all state changes on the rising edge
//   rst_i        synchronous active-high reset
//   mem_read_i   load request (level)
//   mem_write_i  store request (level)
//   addr_i       byte address
//   wdata_i      store data
//   rdata_o      registered load data, held until the next load response
//   stall_o      core hold request (combinational)
//   done_o       one-cycle response pulse
//   err_o        access rejected, valid with done_o
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        stall_o,
  output logic        done_o,
  output logic        err_o
);

  localparam int          AW    = $clog2(DEPTH_WORDS);
  // First byte address past the array; 33 bits so large depths cannot wrap.
  localparam logic [32:0] LIMIT = 33'(DEPTH_WORDS) << 2;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t          state_q;
  logic [3:0]      cnt_q;
  logic [AW-1:0]   idx_q;
  logic [31:0]     wdata_q;
  logic            rd_q;
  logic            wr_q;
  logic            err_q;
  logic [31:0]     rdata_q;
  logic            done_q;
  logic            err_out_q;

  logic [31:0]     mem [DEPTH_WORDS];

  logic            req;
  logic            req_err;
  logic [AW-1:0]   cur_idx;
  logic [31:0]     cur_wdata;
  logic            cur_rd;
  logic            cur_wr;
  logic            cur_err;
  logic            enter_resp;

  assign req     = mem_read_i | mem_write_i;
  assign req_err = (addr_i[1:0] != 2'b00)
                 | ({1'b0, addr_i} >= LIMIT)
                 | (mem_read_i & mem_write_i);

  // RESP can be entered straight from IDLE (error or zero wait states), in
  // which case the access has not been latched yet and the live inputs are
  // the ones to use.
  always_comb begin
    if (state_q == S_IDLE) begin
      cur_idx   = addr_i[AW+1:2];
      cur_wdata = wdata_i;
      cur_rd    = mem_read_i;
      cur_wr    = mem_write_i;
      cur_err   = req_err;
    end else begin
      cur_idx   = idx_q;
      cur_wdata = wdata_q;
      cur_rd    = rd_q;
      cur_wr    = wr_q;
      cur_err   = err_q;
    end
  end

  assign enter_resp = ((state_q == S_IDLE) && req && (req_err || (WAIT_CYCLES == 0)))
                    || ((state_q == S_WAIT) && (cnt_q == 4'd0));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      idx_q     <= '0;
      wdata_q   <= 32'd0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= 32'd0;
      done_q    <= 1'b0;
      err_out_q <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      err_out_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req) begin
            idx_q   <= addr_i[AW+1:2];
            wdata_q <= wdata_i;
            rd_q    <= mem_read_i;
            wr_q    <= mem_write_i;
            err_q   <= req_err;
            if (req_err || (WAIT_CYCLES == 0)) begin
              state_q <= S_RESP;
            end else begin
              cnt_q   <= 4'(WAIT_CYCLES - 1);
              state_q <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (cnt_q == 4'd0) state_q <= S_RESP;
          else               cnt_q   <= cnt_q - 4'd1;
        end
        S_RESP:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase

      // Response outputs are loaded on the edge into RESP so they are
      // registered and line up with the RESP cycle.
      if (enter_resp) begin
        done_q    <= 1'b1;
        err_out_q <= cur_err;
        if (cur_rd) rdata_q <= cur_err ? 32'd0 : mem[cur_idx];
      end
    end
  end

  // Storage write: a reset on the same edge aborts the access.
  always_ff @(posedge clk_i) begin
    if (!rst_i && enter_resp && cur_wr && !cur_err) begin
      mem[cur_idx] <= cur_wdata;
    end
  end

  assign stall_o = ~rst_i & (((state_q == S_IDLE) & req) | (state_q == S_WAIT));
  assign rdata_o = rdata_q;
  assign done_o  = done_q;
  assign err_o   = err_out_q;

endmodule
